qkv_proj_scheduler: RTL

- Parametrised sequencer for the QKV projection stage of an encoder block.
- Drives weight-SRAM, patch-SRAM and QKV accumulation-SRAM addressing plus PE-array control across any (tokens, channel) configuration set at run time.
- Generalises the fixed 27x27x64 schedule to all five block dimensions (64..260 channels, 7..27 spatial).
- Adds a start/busy/done handshake, stall, first-group write-through and a config error flag.

---
 rtl/qkv_proj_scheduler_if.sv | 55 +++++
 rtl/qkv_proj_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qkv_proj_scheduler_if.sv
// qkv_proj_scheduler_if: control and SRAM/PE bus of the QKV projection scheduler.
//
// Signals
//   start, cfg_tokens, cfg_channel, stall  : pass request and flow control (controller side)
//   busy, done, err                         : pass status
//   pe_en, is_wt                            : PE array control
//   wt_rd_en/wt_addr, patch_rd_en/patch_addr: weight and patch SRAM reads
//   acc_rd_en/acc_rd_addr, acc_wr_en/acc_wr_addr, acc_first : accumulation SRAM
//   group_idx                               : current channel group
//   perf_busy_cyc, perf_stall_cyc           : performance counters (zero unless enabled)
//
// Modports
//   master : the controller that issues passes and observes the schedule
//   slave  : the scheduler itself
interface qkv_proj_scheduler_if #(
    parameter int unsigned TOK_W  = 10,
    parameter int unsigned CH_W   = 9,
    parameter int unsigned ADDR_W = 16
);
    logic              start;
    logic [TOK_W-1:0]  cfg_tokens;
    logic [CH_W-1:0]   cfg_channel;
    logic              stall;
    logic              busy;
    logic              done;
    logic              err;
    logic              pe_en;
    logic              is_wt;
    logic              wt_rd_en;
    logic [ADDR_W-1:0] wt_addr;
    logic              patch_rd_en;
    logic [ADDR_W-1:0] patch_addr;
    logic              acc_rd_en;
    logic [ADDR_W-1:0] acc_rd_addr;
    logic              acc_wr_en;
    logic [ADDR_W-1:0] acc_wr_addr;
    logic              acc_first;
    logic [CH_W-1:0]   group_idx;
    logic [31:0]       perf_busy_cyc;
    logic [31:0]       perf_stall_cyc;

    modport master (
        output start, cfg_tokens, cfg_channel, stall,
        input  busy, done, err, pe_en, is_wt, wt_rd_en, wt_addr, patch_rd_en, patch_addr,
               acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_first, group_idx,
               perf_busy_cyc, perf_stall_cyc
    );

    modport slave (
        input  start, cfg_tokens, cfg_channel, stall,
        output busy, done, err, pe_en, is_wt, wt_rd_en, wt_addr, patch_rd_en, patch_addr,
               acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_first, group_idx,
               perf_busy_cyc, perf_stall_cyc
    );
endinterface

// File: rtl/qkv_proj_scheduler.sv
// qkv_proj_scheduler: sequencer for the QKV projection stage of an encoder block.
//
// For each channel group g (DEPTH input channels) it loads DEPTH weight rows, streams
// cfg_tokens patch rows through the PE array, then drains the PE pipeline while the
// accumulation SRAM is read (groups > 0) and written for every token.
//
// Ports
//   clk    : clock
//   reset  : asynchronous active-low reset; aborts any pass without a done pulse
//   bus    : qkv_proj_scheduler_if.slave (start/cfg/stall in; status, PE control,
//            SRAM addressing, group index and perf counters out)
//
// Optional feature: define QKV_SCHED_PERF_EN to enable the busy/stall cycle counters.
// Without it perf_busy_cyc and perf_stall_cyc are tied to zero.
module qkv_proj_scheduler #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LAT    = 19,
    parameter int unsigned TOK_W  = 10,
    parameter int unsigned CH_W   = 9,
    parameter int unsigned ADDR_W = 16
) (
    input logic                 clk,
    input logic                 reset,
    qkv_proj_scheduler_if.slave bus
);

    localparam int unsigned KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW = $clog2(LAT + 2);

    typedef enum logic [2:0] {
        StIdle,
        StWtLoad,
        StFeat,
        StDrain,
        StFin
    } state_e;

    state_e            state_q, state_d;
    logic [TOK_W-1:0]  tokens_q, tokens_d;
    logic [CH_W-1:0]   groups_q, groups_d;
    logic [CH_W-1:0]   g_q, g_d;
    logic [KW-1:0]     k_q, k_d;
    logic [TOK_W-1:0]  t_q, t_d;
    logic [DW-1:0]     d_q, d_d;
    logic              err_q, err_d;

    // Stall only freezes the schedule once a pass has been accepted.
    logic hold;
    logic cfg_bad;
    logic busy_int;

    assign hold     = bus.stall && (state_q != StIdle);
    assign busy_int = (state_q == StWtLoad) || (state_q == StFeat) || (state_q == StDrain);
    assign cfg_bad  = (bus.cfg_tokens == '0) || (bus.cfg_channel == '0) ||
                      ((bus.cfg_channel % CH_W'(DEPTH)) != '0);

    // ------------------------------------------------------------------------
    // FSM next state and counters
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        tokens_d = tokens_q;
        groups_d = groups_q;
        g_d      = g_q;
        k_d      = k_q;
        t_d      = t_q;
        d_d      = d_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    tokens_d = bus.cfg_tokens;
                    groups_d = bus.cfg_channel / CH_W'(DEPTH);
                    err_d    = cfg_bad;
                    g_d      = '0;
                    k_d      = '0;
                    t_d      = '0;
                    d_d      = '0;
                    state_d  = cfg_bad ? StFin : StWtLoad;
                end
            end
            StWtLoad: begin
                if (!hold) begin
                    if (k_q == KW'(DEPTH - 1)) begin
                        t_d     = '0;
                        state_d = StFeat;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StFeat: begin
                if (!hold) begin
                    if (t_q == TOK_W'(tokens_q - 1'b1)) begin
                        d_d     = '0;
                        state_d = StDrain;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                // LAT+1 cycles: the last token's write lands in the final one.
                if (!hold) begin
                    if (d_q == DW'(LAT)) begin
                        if (g_q == CH_W'(groups_q - 1'b1)) begin
                            state_d = StFin;
                        end else begin
                            g_d     = g_q + 1'b1;
                            k_d     = '0;
                            state_d = StWtLoad;
                        end
                    end else begin
                        d_d = d_q + 1'b1;
                    end
                end
            end
            StFin: begin
                if (!hold) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            tokens_q <= '0;
            groups_q <= '0;
            g_q      <= '0;
            k_q      <= '0;
            t_q      <= '0;
            d_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tokens_q <= tokens_d;
            groups_q <= groups_d;
            g_q      <= g_d;
            k_q      <= k_d;
            t_q      <= t_d;
            d_q      <= d_d;
            err_q    <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Accumulation delay line: tracks each patch read until the PE result is valid
    // (LAT stages), plus one more stage for the read-modify-write of the accumulator.
    // ------------------------------------------------------------------------
    logic [LAT-1:0]   dl_vld_q;
    logic [LAT-1:0]   dl_first_q;
    logic [TOK_W-1:0] dl_tok_q [LAT];
    logic             wr_vld_q;
    logic             wr_first_q;
    logic [TOK_W-1:0] wr_tok_q;
    logic             feed_vld;

    assign feed_vld = (state_q == StFeat);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_vld_q   <= '0;
            dl_first_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                dl_tok_q[i] <= '0;
            end
            wr_vld_q   <= 1'b0;
            wr_first_q <= 1'b0;
            wr_tok_q   <= '0;
        end else if (!hold) begin
            dl_vld_q    <= {dl_vld_q[LAT-2:0], feed_vld};
            dl_first_q  <= {dl_first_q[LAT-2:0], (g_q == '0)};
            dl_tok_q[0] <= t_q;
            for (int i = 1; i < int'(LAT); i++) begin
                dl_tok_q[i] <= dl_tok_q[i-1];
            end
            wr_vld_q   <= dl_vld_q[LAT-1];
            wr_first_q <= dl_first_q[LAT-1];
            wr_tok_q   <= dl_tok_q[LAT-1];
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.busy        = busy_int;
    assign bus.done        = (state_q == StFin);
    assign bus.err         = err_q;
    assign bus.pe_en       = busy_int && !bus.stall;
    assign bus.is_wt       = (state_q == StWtLoad);
    assign bus.group_idx   = g_q;

    assign bus.wt_rd_en    = (state_q == StWtLoad) && !bus.stall;
    assign bus.wt_addr     = ADDR_W'(g_q) * ADDR_W'(DEPTH) + ADDR_W'(k_q);

    // Channel-group-major patch layout: group g occupies rows g*T .. g*T+T-1.
    assign bus.patch_rd_en = (state_q == StFeat) && !bus.stall;
    assign bus.patch_addr  = ADDR_W'(g_q) * ADDR_W'(tokens_q) + ADDR_W'(t_q);

    // Group 0 writes the PE result straight through, so it never reads the accumulator.
    assign bus.acc_rd_en   = dl_vld_q[LAT-1] && !dl_first_q[LAT-1] && !hold;
    assign bus.acc_rd_addr = ADDR_W'(dl_tok_q[LAT-1]);
    assign bus.acc_wr_en   = wr_vld_q && !hold;
    assign bus.acc_wr_addr = ADDR_W'(wr_tok_q);
    assign bus.acc_first   = wr_vld_q && wr_first_q;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef QKV_SCHED_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;
    logic        start_acc;

    assign start_acc = bus.start && (state_q == StIdle);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else if (start_acc) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_int && (perf_busy_q != '1)) begin
                perf_busy_q <= perf_busy_q + 1'b1;
            end
            if (busy_int && bus.stall && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
        end
    end

    assign bus.perf_busy_cyc  = perf_busy_q;
    assign bus.perf_stall_cyc = perf_stall_q;
`else
    assign bus.perf_busy_cyc  = '0;
    assign bus.perf_stall_cyc = '0;
`endif

endmodule
